// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// FSM states and small op-decoding helpers.
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } opE;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } stateE;

    // MULT and DIV are the signed variants (op[0] == 0).
    function automatic logic opIsSigned(input logic [1:0] op);
        return !op[0];
    endfunction

    function automatic logic opIsDiv(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply or restoring shift-subtract divide
// on unsigned magnitudes held in the {accHi, accLo} pair.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             isDiv,
    input  logic [WIDTH-1:0] accHi,
    input  logic [WIDTH-1:0] accLo,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] nextHi,
    output logic [WIDTH-1:0] nextLo
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] shifted;
    logic           fits;

    always_comb begin
        sum     = {1'b0, accHi} + (accLo[0] ? {1'b0, operand} : '0);
        shifted = {accHi, accLo[WIDTH-1]};
        fits    = shifted >= {1'b0, operand};
        if (isDiv) begin
            // Partial remainder stays below the divisor, so the W-bit difference is exact.
            if (fits) begin
                nextHi = shifted[WIDTH-1:0] - operand;
                nextLo = {accLo[WIDTH-2:0], 1'b1};
            end else begin
                nextHi = shifted[WIDTH-1:0];
                nextLo = {accLo[WIDTH-2:0], 1'b0};
            end
        end else begin
            nextHi = sum[WIDTH:1];
            nextLo = {sum[0], accLo[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Fixed-latency iterative MULT/MULTU/DIV/DIVU unit: WIDTH CALC cycles on
// magnitudes, then one FIX cycle for sign correction and hi/lo write-back.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    stateE            state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       opReg;
    logic [WIDTH-1:0] aReg;
    logic             divZero;
    logic             negRes;
    logic             negRem;
    logic [WIDTH-1:0] accHi;
    logic [WIDTH-1:0] accLo;
    logic [WIDTH-1:0] operand;

    logic             negA, negB;
    logic [WIDTH-1:0] magA, magB;
    logic [WIDTH-1:0] stepHi, stepLo;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0] fixHi, fixLo;

    always_comb begin
        negA = opIsSigned(op) && a[WIDTH-1];
        negB = opIsSigned(op) && b[WIDTH-1];
        magA = negA ? -a : a;
        magB = negB ? -b : b;
    end

    muldiv_step #(.WIDTH(WIDTH)) uStep (
        .isDiv  (opIsDiv(opReg)),
        .accHi  (accHi),
        .accLo  (accLo),
        .operand(operand),
        .nextHi (stepHi),
        .nextLo (stepLo)
    );

    // Most-negative / -1 falls out naturally: magnitude 2^(W-1) negates to itself.
    always_comb begin
        prod  = negRes ? -{accHi, accLo} : {accHi, accLo};
        fixHi = prod[2*WIDTH-1:WIDTH];
        fixLo = prod[WIDTH-1:0];
        if (opIsDiv(opReg)) begin
            if (divZero) begin
                fixHi = aReg;
                fixLo = '1;
            end else begin
                fixLo = negRes ? -accLo : accLo;
                fixHi = negRem ? -accHi : accHi;
            end
        end
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            opReg   <= '0;
            aReg    <= '0;
            divZero <= 1'b0;
            negRes  <= 1'b0;
            negRem  <= 1'b0;
            accHi   <= '0;
            accLo   <= '0;
            operand <= '0;
            done    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !cancel) begin
                        opReg   <= op;
                        aReg    <= a;
                        divZero <= (b == '0);
                        negRes  <= negA ^ negB;
                        negRem  <= negA;
                        accHi   <= '0;
                        accLo   <= opIsDiv(op) ? magA : magB;
                        operand <= opIsDiv(op) ? magB : magA;
                        cnt     <= '0;
                        state   <= CALC;
                    end
                end
                CALC: begin
                    if (cancel) begin
                        state <= IDLE;
                    end else begin
                        accHi <= stepHi;
                        accLo <= stepLo;
                        cnt   <= cnt + 1'b1;
                        if (cnt == LAST_STEP)
                            state <= FIX;
                    end
                end
                FIX: begin
                    if (cancel) begin
                        state <= IDLE;
                    end else begin
                        hi    <= fixHi;
                        lo    <= fixLo;
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit (WIDTH=32): results, latency, ignored starts,
// back-to-back issue, cancel and reset abort.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic        cancel;
    logic        busy, done;
    logic [31:0] hi, lo;

    int nTests = 0;
    int nFail  = 0;
    int doneCyc, doneCnt, busyCnt;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .cancel(cancel),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nTests++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Presents a request for one edge (edge 0); returns at the negedge of cycle 1
    // with the inputs scrambled so later changes are shown not to matter.
    task automatic startOp(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0; op = ~o; a = $urandom; b = $urandom;
    endtask

    // Observes cycles 1..n (relative to the current cycle 1); optional start pulse.
    task automatic watch(input int n, input int pulseAt, output int dCyc, output int dCnt,
                         output int bCnt);
        dCyc = 0; dCnt = 0; bCnt = 0;
        for (int c = 1; c <= n; c++) begin
            if (done === 1'b1) begin
                dCnt++;
                if (dCyc == 0) dCyc = c;
            end
            if (busy === 1'b1) bCnt++;
            start = (c == pulseAt);
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; cancel = 1'b0; op = '0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_hilo", {hi, lo}, 64'd0);

        // Reset overrides start
        reset = 1'b1; start = 1'b1; op = OP_MULTU; a = 32'd3; b = 32'd3;
        @(negedge clk);
        reset = 1'b0; start = 1'b0;
        chk("reset_over_start", 64'(busy), 64'd0);

        // MULT -3 * 7, full latency and busy profile
        startOp(OP_MULT, 32'hFFFF_FFFD, 32'd7);
        watch(35, 0, doneCyc, doneCnt, busyCnt);
        chk("mult_done_cyc", 64'(doneCyc), 64'd34);
        chk("mult_done_cnt", 64'(doneCnt), 64'd1);
        chk("mult_busy_cnt", 64'(busyCnt), 64'd33);
        chk("mult_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);

        // MULTU max*max with an ignored start in cycle 5
        startOp(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        watch(35, 5, doneCyc, doneCnt, busyCnt);
        chk("multu_done_cyc", 64'(doneCyc), 64'd34);
        chk("multu_busy_cnt", 64'(busyCnt), 64'd33);
        chk("multu_hilo", {hi, lo}, 64'hFFFF_FFFE_0000_0001);

        // MULT -2 * -3
        startOp(OP_MULT, 32'hFFFF_FFFE, 32'hFFFF_FFFD);
        watch(35, 0, doneCyc, doneCnt, busyCnt);
        chk("mult_negneg", {hi, lo}, 64'h0000_0000_0000_0006);

        // DIV -7 / 2 -> q=-3, r=-1
        startOp(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        watch(35, 0, doneCyc, doneCnt, busyCnt);
        chk("div_done_cyc", 64'(doneCyc), 64'd34);
        chk("div_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);

        // DIV 7 / -2 -> q=-3, r=1
        startOp(OP_DIV, 32'd7, 32'hFFFF_FFFE);
        watch(35, 0, doneCyc, doneCnt, busyCnt);
        chk("div_pos_neg", {hi, lo}, 64'h0000_0001_FFFF_FFFD);

        // DIVU 100 / 7 -> q=14, r=2
        startOp(OP_DIVU, 32'd100, 32'd7);
        watch(35, 0, doneCyc, doneCnt, busyCnt);
        chk("divu_hilo", {hi, lo}, 64'h0000_0002_0000_000E);

        // DIVU by zero
        startOp(OP_DIVU, 32'h64, 32'd0);
        watch(35, 0, doneCyc, doneCnt, busyCnt);
        chk("divu0_done_cyc", 64'(doneCyc), 64'd34);
        chk("divu0_hilo", {hi, lo}, 64'h0000_0064_FFFF_FFFF);

        // DIV by zero with a negative dividend keeps the raw dividend in hi
        startOp(OP_DIV, 32'hFFFF_FFF9, 32'd0);
        watch(35, 0, doneCyc, doneCnt, busyCnt);
        chk("div0_hilo", {hi, lo}, 64'hFFFF_FFF9_FFFF_FFFF);

        // DIV most-negative / -1, then MULTU 2*3 issued in the done cycle
        startOp(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        watch(33, 0, doneCyc, doneCnt, busyCnt);
        chk("ovf_done", 64'(done), 64'd1);
        chk("ovf_hilo", {hi, lo}, 64'h0000_0000_8000_0000);
        start = 1'b1; op = OP_MULTU; a = 32'd2; b = 32'd3;
        @(negedge clk);
        start = 1'b0; a = 32'd9; b = 32'd9;
        chk("b2b_busy", 64'(busy), 64'd1);
        watch(33, 0, doneCyc, doneCnt, busyCnt);
        chk("b2b_done_68", 64'(done), 64'd1);
        chk("b2b_hilo", {hi, lo}, 64'h0000_0000_0000_0006);

        // Cancel in cycle 10 of a MULT
        startOp(OP_MULT, 32'd5, 32'd6);
        watch(9, 0, doneCyc, doneCnt, busyCnt);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        chk("cancel_busy", 64'(busy), 64'd0);
        watch(40, 0, doneCyc, doneCnt, busyCnt);
        chk("cancel_no_done", 64'(doneCnt), 64'd0);
        chk("cancel_hilo", {hi, lo}, 64'h0000_0000_0000_0006);

        // start together with cancel in IDLE is ignored
        start = 1'b1; cancel = 1'b1; op = OP_MULTU; a = 32'd4; b = 32'd4;
        @(negedge clk);
        start = 1'b0; cancel = 1'b0;
        chk("idle_cancel_wins", 64'(busy), 64'd0);

        // Reset in cycle 20 of a DIV
        startOp(OP_DIV, 32'd1000, 32'd3);
        watch(19, 0, doneCyc, doneCnt, busyCnt);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_mid_busy", 64'(busy), 64'd0);
        chk("rst_mid_hilo", {hi, lo}, 64'd0);
        watch(40, 0, doneCyc, doneCnt, busyCnt);
        chk("rst_mid_no_done", 64'(doneCnt), 64'd0);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
